// File: rtl/mtr_ramp_ctrl_pkg.sv
// Shared types for the motor ramp controller: speed word width, signed
// speed type and the sequencer state encoding.
package mtr_ctrl_pkg;

  localparam int unsigned SPD_W = 12;

  typedef logic signed [SPD_W-1:0] spd_t;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    STOP,
    FAULT
  } mtr_state_t;

endpackage

// File: rtl/mtr_ramp_ctrl_if.sv
// Command bus from navigation/PID logic to the ramp controller.
//   cmd_vld  : one-cycle strobe, capture cmd_lft/cmd_rght as new targets
//   cmd_lft  : signed left target speed
//   cmd_rght : signed right target speed
interface mtr_ramp_ctrl_if;
  import mtr_ctrl_pkg::*;

  logic cmd_vld;
  spd_t cmd_lft;
  spd_t cmd_rght;

  modport master (output cmd_vld, cmd_lft, cmd_rght);
  modport slave  (input  cmd_vld, cmd_lft, cmd_rght);
endinterface

// File: rtl/mtr_ramp_ctrl_spd_slew.sv
// One speed channel: holds the current speed register and moves it toward
// target by at most `step` on each tick.
//   clk, rst   : clock, async active-high reset (current -> 0)
//   tick       : ramp tick strobe; slew only happens on tick
//   step       : max |change| per tick (unsigned)
//   target     : signed target speed
//   force_zero : clear current on the next edge regardless of tick
//   cur        : registered current speed
module spd_slew
  import mtr_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [SPD_W-1:0] step,
  input  spd_t             target,
  input  logic             force_zero,
  output spd_t             cur
);

  spd_t               cur_q, cur_d;
  logic signed [SPD_W:0] diff;
  logic        [SPD_W:0] mag;

  always_comb begin
    // One extra bit keeps target-current in range for any pair of inputs.
    diff  = {target[SPD_W-1], target} - {cur_q[SPD_W-1], cur_q};
    mag   = diff[SPD_W] ? -diff : diff;
    cur_d = cur_q;
    if (force_zero) begin
      cur_d = '0;
    end else if (tick) begin
      if (mag <= {1'b0, step}) begin
        cur_d = target;
      end else if (diff[SPD_W]) begin
        cur_d = cur_q - $signed(step);
      end else begin
        cur_d = cur_q + $signed(step);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_q <= '0;
    else     cur_q <= cur_d;
  end

  assign cur = cur_q;

endmodule

// File: rtl/mtr_ramp_ctrl.sv
// Motor-command sequencer: slew-limits left/right speed words to the motor
// driver and sequences enable, controlled stop, emergency stop and
// low-battery shutdown.
//   clk, rst  : clock, async active-high reset
//   en        : level, motors allowed to run
//   cmd       : command bus (slave) carrying cmd_vld/cmd_lft/cmd_rght
//   estop     : level, emergency stop
//   vbatt     : unsigned battery reading
//   lft_spd   : registered left speed to driver
//   rght_spd  : registered right speed to driver
//   at_tgt    : registered, high while in HOLD
//   batt_low  : sticky low-battery flag
//   fault     : high in FAULT
module mtr_ramp_ctrl
  import mtr_ctrl_pkg::*;
#(
  parameter int unsigned      STEP     = 8,
  parameter int unsigned      BRK_STEP = 32,
  parameter int unsigned      TICK_DIV = 1024,
  parameter logic [SPD_W-1:0] BATT_MIN = 12'hA00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  mtr_ramp_ctrl_if.slave       cmd,
  input  logic                 estop,
  input  logic [SPD_W-1:0]     vbatt,
  output spd_t                 lft_spd,
  output spd_t                 rght_spd,
  output logic                 at_tgt,
  output logic                 batt_low,
  output logic                 fault
);

  localparam int unsigned      CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [SPD_W-1:0] STEP_V = SPD_W'(STEP);
  localparam logic [SPD_W-1:0] BRK_V  = SPD_W'(BRK_STEP);

  mtr_state_t       state_q, state_d;
  spd_t             tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SPD_W-1:0] vbatt_q;
  logic             batt_low_q, batt_low_d;
  logic             at_tgt_q, at_tgt_d;
  logic             tick;
  logic [SPD_W-1:0] step_sel;
  logic             force_zero;
  logic             both_at, both_zero, cmd_new;

  assign tick       = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign step_sel   = (state_q == STOP) ? BRK_V : STEP_V;
  assign force_zero = (state_q == FAULT) || (state_q == IDLE);
  assign both_at    = (lft_spd == tgt_l_q) && (rght_spd == tgt_r_q);
  assign both_zero  = (lft_spd == '0) && (rght_spd == '0);
  assign cmd_new    = (cmd.cmd_lft != tgt_l_q) || (cmd.cmd_rght != tgt_r_q);

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    batt_low_d = batt_low_q || (vbatt_q < BATT_MIN);
    state_d    = state_q;
    tgt_l_d    = tgt_l_q;
    tgt_r_d    = tgt_r_q;
    if (estop) begin
      state_d = FAULT;
      tgt_l_d = '0;
      tgt_r_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd.cmd_vld && en && !batt_low_q) begin
            tgt_l_d = cmd.cmd_lft;
            tgt_r_d = cmd.cmd_rght;
            state_d = RAMP;
          end
        end
        RAMP, HOLD: begin
          if (batt_low_q || !en) begin
            // Zero targets on entry so the STOP slew heads for 0.
            tgt_l_d = '0;
            tgt_r_d = '0;
            state_d = STOP;
          end else if (cmd.cmd_vld) begin
            tgt_l_d = cmd.cmd_lft;
            tgt_r_d = cmd.cmd_rght;
            if (cmd_new) state_d = RAMP;
          end else if (both_at) begin
            state_d = HOLD;
          end
        end
        STOP: begin
          if (both_zero) state_d = IDLE;
        end
        FAULT: begin
          tgt_l_d = '0;
          tgt_r_d = '0;
          if (!en) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    at_tgt_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tgt_l_q    <= '0;
      tgt_r_q    <= '0;
      cnt_q      <= '0;
      vbatt_q    <= '1;
      batt_low_q <= 1'b0;
      at_tgt_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_l_q    <= tgt_l_d;
      tgt_r_q    <= tgt_r_d;
      cnt_q      <= cnt_d;
      vbatt_q    <= vbatt;
      batt_low_q <= batt_low_d;
      at_tgt_q   <= at_tgt_d;
    end
  end

  spd_slew u_slew_lft (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .step       (step_sel),
    .target     (tgt_l_q),
    .force_zero (force_zero),
    .cur        (lft_spd)
  );

  spd_slew u_slew_rght (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .step       (step_sel),
    .target     (tgt_r_q),
    .force_zero (force_zero),
    .cur        (rght_spd)
  );

  assign at_tgt   = at_tgt_q;
  assign batt_low = batt_low_q;
  assign fault    = (state_q == FAULT);

endmodule

// File: tb/tb_mtr_ramp_ctrl.sv
// Directed testbench for mtr_ramp_ctrl with STEP=8, BRK_STEP=32, TICK_DIV=4.
// Ticks fall on every 4th rising edge after reset release; cyc tracks that.
module tb_mtr_ramp_ctrl;
  import mtr_ctrl_pkg::*;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       estop = 1'b0;
  logic [11:0] vbatt = 12'hFFF;
  spd_t       lft_spd, rght_spd;
  logic       at_tgt, batt_low, fault;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mtr_ramp_ctrl_if cmd_if ();

  mtr_ramp_ctrl #(
    .STEP     (8),
    .BRK_STEP (32),
    .TICK_DIV (TD),
    .BATT_MIN (12'hA00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cmd      (cmd_if.slave),
    .estop    (estop),
    .vbatt    (vbatt),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .at_tgt   (at_tgt),
    .batt_low (batt_low),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [31:0] act,
                           input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic next_tick();
    do edge1(); while (cyc % TD != 0);
  endtask

  task automatic do_reset();
    cmd_if.cmd_vld  = 1'b0;
    cmd_if.cmd_lft  = '0;
    cmd_if.cmd_rght = '0;
    estop = 1'b0;
    vbatt = 12'hFFF;
    en    = 1'b1;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // Called just after a tick edge so the capture edge is never a tick edge.
  task automatic send_cmd(input int l, input int r);
    cmd_if.cmd_vld  = 1'b1;
    cmd_if.cmd_lft  = spd_t'(l);
    cmd_if.cmd_rght = spd_t'(r);
    edge1();
    cmd_if.cmd_vld  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and basic ramp to (100, -100)
    do_reset();
    check_val("rst_lft", lft_spd, 0);
    check_val("rst_rght", rght_spd, 0);
    check_val("rst_at_tgt", at_tgt, 0);
    check_val("rst_batt_low", batt_low, 0);
    check_val("rst_fault", fault, 0);
    next_tick();
    send_cmd(100, -100);
    for (int k = 1; k <= 13; k++) begin
      next_tick();
      check_val("ramp_lft", lft_spd, (k < 13) ? 8 * k : 100);
      check_val("ramp_rght", rght_spd, (k < 13) ? -8 * k : -100);
      if (k == 1) begin
        edge1();
        check_val("ramp_hold_between_ticks", lft_spd, 8);
      end
    end
    check_val("ramp_at_tgt_before_hold", at_tgt, 0);
    edge1();
    check_val("ramp_at_tgt_hold", at_tgt, 1);

    // Retarget mid-ramp at +40 to (0, 0)
    do_reset();
    next_tick();
    send_cmd(100, 100);
    repeat (5) next_tick();
    check_val("retgt_start", lft_spd, 40);
    send_cmd(0, 0);
    for (int k = 1; k <= 7; k++) begin
      next_tick();
      check_val("retgt_lft", lft_spd, (k < 5) ? 40 - 8 * k : 0);
    end
    check_val("retgt_at_tgt", at_tgt, 1);

    // Full-scale ramp, then controlled stop by dropping en
    do_reset();
    next_tick();
    send_cmd(2047, -2048);
    for (int k = 1; k <= 256; k++) begin
      next_tick();
      if (k == 1)   check_val("fs_lft_t1", lft_spd, 8);
      if (k == 255) check_val("fs_lft_t255", lft_spd, 2040);
    end
    check_val("fs_lft_end", lft_spd, 2047);
    check_val("fs_rght_end", rght_spd, -2048);
    edge1();
    check_val("fs_at_tgt", at_tgt, 1);
    next_tick();
    en = 1'b0;
    edge1();
    check_val("stop_at_tgt_drop", at_tgt, 0);
    for (int k = 1; k <= 64; k++) begin
      next_tick();
      if (k == 1 || k == 32 || k == 63 || k == 64) begin
        check_val("stop_lft", lft_spd, (2047 - 32 * k > 0) ? 2047 - 32 * k : 0);
        check_val("stop_rght", rght_spd, -2048 + 32 * k);
      end
    end
    edge1();
    en = 1'b1;
    next_tick();
    send_cmd(16, -16);
    next_tick();
    check_val("stop_idle_accepts", lft_spd, 8);

    // Estop during ramp, FAULT exit only with en=0
    do_reset();
    next_tick();
    send_cmd(100, -100);
    repeat (3) next_tick();
    estop = 1'b1;
    edge1();
    check_val("estop_fault_rise", fault, 1);
    check_val("estop_lft_pre", lft_spd, 24);
    edge1();
    check_val("estop_lft_zero", lft_spd, 0);
    check_val("estop_rght_zero", rght_spd, 0);
    estop = 1'b0;
    send_cmd(50, 50);
    repeat (2) next_tick();
    check_val("estop_stay_fault", fault, 1);
    check_val("estop_cmd_ignored", lft_spd, 0);
    en = 1'b0;
    edge1();
    check_val("estop_exit_idle", fault, 0);
    en = 1'b1;
    next_tick();
    send_cmd(8, -8);
    next_tick();
    check_val("estop_idle_lft", lft_spd, 8);
    check_val("estop_idle_rght", rght_spd, -8);

    // Low battery from HOLD
    do_reset();
    next_tick();
    send_cmd(50, 50);
    repeat (7) next_tick();
    check_val("batt_hold_lft", lft_spd, 50);
    next_tick();
    check_val("batt_hold_at_tgt", at_tgt, 1);
    vbatt = 12'h9FF;
    edge1();
    check_val("batt_low_edge1", batt_low, 0);
    edge1();
    check_val("batt_low_edge2", batt_low, 1);
    check_val("batt_at_tgt_edge2", at_tgt, 1);
    edge1();
    check_val("batt_stop_at_tgt", at_tgt, 0);
    next_tick();
    check_val("batt_stop_t1", lft_spd, 18);
    next_tick();
    check_val("batt_stop_t2", rght_spd, 0);
    vbatt = 12'hFFF;
    edge1();
    next_tick();
    send_cmd(64, 64);
    repeat (3) next_tick();
    check_val("batt_cmd_ignored", lft_spd, 0);
    check_val("batt_sticky", batt_low, 1);

    // Async reset mid-ramp
    do_reset();
    next_tick();
    send_cmd(100, 100);
    repeat (3) next_tick();
    check_val("arst_pre", lft_spd, 24);
    edge1();
    edge1();
    #3 rst = 1'b1;
    #1;
    check_val("arst_lft_immediate", lft_spd, 0);
    check_val("arst_rght_immediate", rght_spd, 0);
    #2 rst = 1'b0;
    cyc = 0;
    check_val("arst_at_tgt", at_tgt, 0);
    check_val("arst_fault", fault, 0);
    send_cmd(8, 8);
    edge1();
    edge1();
    check_val("arst_no_early_tick", lft_spd, 0);
    edge1();
    check_val("arst_tick4_lft", lft_spd, 8);
    check_val("arst_tick4_rght", rght_spd, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
